gnrc_bin2onehot_stream: RTL and testbench

Streaming, handshaked binary-to-one-hot/thermometer decoder with an arbitrary output width M ≤ 2^N, out-of-range detection and a 2-entry skid buffer. It sits between a valid/ready producer of binary indices (arbiter grants, pointer updates, channel selects) and consumers that need registered one-hot or thermometer masks. It gives full throughput with no combinational path from ready_i to ready_o.

---
 rtl/gnrc_codec_pkg.sv | 42 ++++
 rtl/gnrc_bin_decode.sv | 52 +++++
 rtl/gnrc_bin2onehot_stream.sv | 154 +++++++++++++++
 tb/tb_gnrc_bin2onehot_stream.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/gnrc_codec_pkg.sv
// -----------------------------------------------------------------------------
// gnrc_codec_pkg
// Shared types and helpers for the binary-to-mask streaming decoder:
//   codec_mode_e   - selects one-hot or thermometer decoding
//   buffer_state_e - occupancy of the two-entry output buffer
//   sat_inc()      - saturating increment for counters up to 64 bits wide
// -----------------------------------------------------------------------------
package gnrc_codec_pkg;

  typedef enum logic [0:0] {
    CODEC_ONEHOT = 1'b0,
    CODEC_THERMO = 1'b1
  } codec_mode_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buffer_state_e;

  localparam int unsigned SAT_MAX_W = 64;

  // Increment val, holding at 2^width-1. Operands are carried at 64 bits so
  // callers of any counter width up to 64 can share the one helper.
  function automatic logic [SAT_MAX_W-1:0] sat_inc(
    input logic [SAT_MAX_W-1:0] val,
    input int unsigned          width
  );
    logic [SAT_MAX_W-1:0] max_v;
    if (width >= SAT_MAX_W) begin
      max_v = {SAT_MAX_W{1'b1}};
    end else begin
      max_v = (64'd1 << width) - 64'd1;
    end
    if (val >= max_v) begin
      return max_v;
    end else begin
      return val + 64'd1;
    end
  endfunction

endpackage

// File: rtl/gnrc_bin_decode.sv
// -----------------------------------------------------------------------------
// gnrc_bin_decode
// Combinational N-bit binary to M-bit one-hot / thermometer decoder.
// Ports:
//   bin  in  N  binary code
//   mask out M  decoded mask (all zeros / all ones for out-of-range codes)
//   oor  out 1  code >= M
// -----------------------------------------------------------------------------
module gnrc_bin_decode
  import gnrc_codec_pkg::*;
#(
  parameter int unsigned N    = 3,
  parameter int unsigned M    = 2**N,
  parameter codec_mode_e MODE = CODEC_ONEHOT
) (
  input  logic [N-1:0] bin,
  output logic [M-1:0] mask,
  output logic         oor
);

  // M held at N+1 bits so that M = 2^N is representable and never flags.
  localparam logic [N:0] M_EXT = (N+1)'(M);

  logic [M-1:0] raw_s;

  // Range check against the output width
  always_comb begin
    oor = ({1'b0, bin} >= M_EXT);
  end

  // Per-bit decode; bit index is compared at N bits
  always_comb begin
    raw_s = {M{1'b0}};
    for (int k = 0; k < M; k++) begin
      case (MODE)
        CODEC_ONEHOT: raw_s[k] = (bin == N'(k));
        CODEC_THERMO: raw_s[k] = (N'(k) <= bin);
        default:      raw_s[k] = 1'b0;
      endcase
    end
  end

  // Force the defined out-of-range pattern
  always_comb begin
    if (oor) begin
      mask = (MODE == CODEC_THERMO) ? {M{1'b1}} : {M{1'b0}};
    end else begin
      mask = raw_s;
    end
  end

endmodule

// File: rtl/gnrc_bin2onehot_stream.sv
// -----------------------------------------------------------------------------
// gnrc_bin2onehot_stream
// valid/ready stream stage that decodes binary codes into registered
// one-hot or thermometer masks, with a 2-entry skid buffer so ready_o
// depends only on registered state (full throughput, no ready path).
// Ports:
//   clk_i      in   1      clock
//   rst_ni     in   1      async active-low reset
//   flush_i    in   1      sync flush of buffered entries
//   valid_i    in   1      input code valid
//   ready_o    out  1      input can be accepted
//   bin_i      in   N      binary code
//   valid_o    out  1      output mask valid
//   ready_i    in   1      downstream accepts
//   mask_o     out  M      decoded mask (oldest entry)
//   oor_o      out  1      presented mask came from an out-of-range code
//   oor_cnt_o  out  CNT_W  saturating count of accepted out-of-range codes
// -----------------------------------------------------------------------------
module gnrc_bin2onehot_stream
  import gnrc_codec_pkg::*;
#(
  parameter int unsigned N     = 3,
  parameter int unsigned M     = 2**N,
  parameter codec_mode_e MODE  = CODEC_ONEHOT,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [N-1:0]     bin_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [M-1:0]     mask_o,
  output logic             oor_o,
  output logic [CNT_W-1:0] oor_cnt_o
);

  buffer_state_e    state_r, state_next_s;
  logic [M-1:0]     main_mask_r, skid_mask_r, dec_mask_s;
  logic             main_oor_r, skid_oor_r, dec_oor_s;
  logic [CNT_W-1:0] oor_cnt_r;
  logic             in_xfer_s, out_xfer_s;
  logic             load_main_new_s, load_main_skid_s, load_skid_s;

  // Decode before storage so each entry is only mask + oor
  gnrc_bin_decode #(
    .N    (N),
    .M    (M),
    .MODE (MODE)
  ) u_decode (
    .bin  (bin_i),
    .mask (dec_mask_s),
    .oor  (dec_oor_s)
  );

  assign ready_o   = (state_r != TWO);
  assign valid_o   = (state_r != EMPTY);
  assign mask_o    = main_mask_r;
  assign oor_o     = main_oor_r;
  assign oor_cnt_o = oor_cnt_r;

  assign in_xfer_s  = valid_i & ready_o & ~flush_i;
  assign out_xfer_s = valid_o & ready_i;

  // Buffer FSM next state and register load selects
  always_comb begin
    state_next_s     = state_r;
    load_main_new_s  = 1'b0;
    load_main_skid_s = 1'b0;
    load_skid_s      = 1'b0;
    if (flush_i) begin
      state_next_s = EMPTY;
    end else begin
      case (state_r)
        EMPTY: begin
          if (in_xfer_s) begin
            load_main_new_s = 1'b1;
            state_next_s    = ONE;
          end else begin
            state_next_s = EMPTY;
          end
        end
        ONE: begin
          if (in_xfer_s && out_xfer_s) begin
            load_main_new_s = 1'b1;
            state_next_s    = ONE;
          end else if (in_xfer_s) begin
            load_skid_s  = 1'b1;
            state_next_s = TWO;
          end else if (out_xfer_s) begin
            state_next_s = EMPTY;
          end else begin
            state_next_s = ONE;
          end
        end
        TWO: begin
          if (out_xfer_s) begin
            load_main_skid_s = 1'b1;
            state_next_s     = ONE;
          end else begin
            state_next_s = TWO;
          end
        end
        default: state_next_s = EMPTY;
      endcase
    end
  end

  // Buffer state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Main (head) entry: new code when passing through, skid when draining
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      main_mask_r <= {M{1'b0}};
      main_oor_r  <= 1'b0;
    end else if (load_main_new_s) begin
      main_mask_r <= dec_mask_s;
      main_oor_r  <= dec_oor_s;
    end else if (load_main_skid_s) begin
      main_mask_r <= skid_mask_r;
      main_oor_r  <= skid_oor_r;
    end
  end

  // Skid entry: catches the code accepted while the head is stalled
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      skid_mask_r <= {M{1'b0}};
      skid_oor_r  <= 1'b0;
    end else if (load_skid_s) begin
      skid_mask_r <= dec_mask_s;
      skid_oor_r  <= dec_oor_s;
    end
  end

  // Out-of-range counter; survives flush, cleared only by reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      oor_cnt_r <= {CNT_W{1'b0}};
    end else if (in_xfer_s && dec_oor_s) begin
      oor_cnt_r <= CNT_W'(sat_inc(64'(oor_cnt_r), CNT_W));
    end
  end

endmodule

// File: tb/tb_gnrc_bin2onehot_stream.sv
// -----------------------------------------------------------------------------
// tb_gnrc_bin2onehot_stream
// Two instances share one input stream:
//   A: N=3, M=6, one-hot,    CNT_W=2 (out-of-range codes 6,7; counter max 3)
//   B: N=3, M=8, thermometer, CNT_W=4 (never out of range)
// Reference: a FIFO queue of accepted codes with capacity two; masks are
// computed from the code with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_gnrc_bin2onehot_stream;
  import gnrc_codec_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, flush, valid, ready;
  logic [2:0] bin;
  logic       rdy_a, val_a, oor_a, rdy_b, val_b, oor_b;
  logic [5:0] mask_a;
  logic [7:0] mask_b;
  logic [1:0] cnt_a;
  logic [3:0] cnt_b;

  gnrc_bin2onehot_stream #(.N(3), .M(6), .MODE(CODEC_ONEHOT), .CNT_W(2)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(valid), .ready_o(rdy_a),
    .bin_i(bin), .valid_o(val_a), .ready_i(ready), .mask_o(mask_a), .oor_o(oor_a),
    .oor_cnt_o(cnt_a)
  );

  gnrc_bin2onehot_stream #(.N(3), .M(8), .MODE(CODEC_THERMO), .CNT_W(4)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(valid), .ready_o(rdy_b),
    .bin_i(bin), .valid_o(val_b), .ready_i(ready), .mask_o(mask_b), .oor_o(oor_b),
    .oor_cnt_o(cnt_b)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int q[$];
  int cnt_a_m = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] exp_onehot(input int c);
    int t;
    t = (c >= 6) ? 0 : (1 << c);
    return t[5:0];
  endfunction

  function automatic logic [7:0] exp_thermo(input int c);
    int t;
    t = (1 << (c + 1)) - 1;
    return t[7:0];
  endfunction

  task automatic check_reset_values();
    check_val("rst_ready_a", rdy_a, 1);
    check_val("rst_valid_a", val_a, 0);
    check_val("rst_mask_a",  mask_a, 0);
    check_val("rst_oor_a",   oor_a, 0);
    check_val("rst_cnt_a",   cnt_a, 0);
    check_val("rst_ready_b", rdy_b, 1);
    check_val("rst_valid_b", val_b, 0);
    check_val("rst_mask_b",  mask_b, 0);
    check_val("rst_oor_b",   oor_b, 0);
    check_val("rst_cnt_b",   cnt_b, 0);
  endtask

  // One cycle: drive, check against the model, clock, advance the model.
  task automatic step(input logic v, input int b, input logic r, input logic f);
    bit in_x, out_x;
    valid = v;
    bin   = 3'(b);
    ready = r;
    flush = f;
    #1;
    check_val("ready_a", rdy_a, q.size() < 2);
    check_val("ready_b", rdy_b, q.size() < 2);
    check_val("valid_a", val_a, q.size() > 0);
    check_val("valid_b", val_b, q.size() > 0);
    if (q.size() > 0) begin
      check_val("mask_a", mask_a, exp_onehot(q[0]));
      check_val("oor_a",  oor_a,  q[0] >= 6);
      check_val("mask_b", mask_b, exp_thermo(q[0]));
      check_val("oor_b",  oor_b,  0);
    end
    check_val("cnt_a", cnt_a, cnt_a_m);
    check_val("cnt_b", cnt_b, 0);
    in_x  = v && (q.size() < 2) && !f;
    out_x = (q.size() > 0) && r;
    @(posedge clk);
    if (f) begin
      q.delete();
    end else begin
      if (out_x) void'(q.pop_front());
      if (in_x)  q.push_back(b);
    end
    if (in_x && b >= 6 && cnt_a_m < 3) cnt_a_m++;
    @(negedge clk);
  endtask

  task automatic async_reset_mid_stream();
    valid = 1'b0;
    ready = 1'b0;
    flush = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_values();
    q.delete();
    cnt_a_m = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    valid = 1'b0;
    ready = 1'b0;
    bin   = 3'd0;
    #2;
    check_reset_values();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back stream with ready held high
    step(1'b1, 0, 1'b1, 1'b0);
    step(1'b1, 5, 1'b1, 1'b0);
    step(1'b1, 7, 1'b1, 1'b0);
    step(1'b1, 2, 1'b1, 1'b0);
    step(1'b1, 6, 1'b1, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);

    // Backpressure: fill both entries, third code held, then drain in order
    step(1'b1, 1, 1'b0, 1'b0);
    step(1'b1, 2, 1'b0, 1'b0);
    step(1'b1, 3, 1'b0, 1'b0);
    step(1'b1, 3, 1'b0, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);

    // Flush while full, then a fresh code
    step(1'b1, 1, 1'b0, 1'b0);
    step(1'b1, 2, 1'b0, 1'b0);
    step(1'b1, 3, 1'b0, 1'b1);
    step(1'b1, 4, 1'b1, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);

    // Flush in ONE with an offered code and a consuming downstream
    step(1'b1, 1, 1'b0, 1'b0);
    step(1'b1, 2, 1'b1, 1'b1);
    step(1'b0, 0, 1'b1, 1'b0);

    // Out-of-range codes saturate the 2-bit counter
    for (int i = 0; i < 5; i++) step(1'b1, 6 + (i % 2), 1'b1, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);

    // Asynchronous reset while entries are held
    step(1'b1, 1, 1'b0, 1'b0);
    step(1'b1, 6, 1'b0, 1'b0);
    async_reset_mid_stream();
    step(1'b1, 5, 1'b1, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(9, 0) < 7) ? 1'b1 : 1'b0,
           int'($urandom_range(7, 0)),
           ($urandom_range(9, 0) < 6) ? 1'b1 : 1'b0,
           ($urandom_range(19, 0) == 0) ? 1'b1 : 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
